div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal: 8..64, even).
REQ-002 SHALL have localparam CNT_W, value clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port clk  input  1  clock, all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request; accepted only when ready_o=1 and cancel_i=0.
REQ-006 SHALL have port cancel_i  input  1  flush; aborts any in-flight operation.
REQ-007 SHALL have port signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port op_a_i  input  WIDTH  dividend, sampled only on accept.
REQ-009 SHALL have port op_b_i  input  WIDTH  divisor, sampled only on accept.
REQ-010 SHALL have port ready_o  output  1  high only in IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse, results valid.
REQ-012 SHALL have port quo_o  output  WIDTH  quotient, held from done_o until next accept.
REQ-013 SHALL have port rem_o  output  WIDTH  remainder, held likewise.
REQ-014 SHALL have port dbz_o  output  1  divide-by-zero flag, qualified by done_o.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX, DONE; IDLE->CALC on accept with op_b_i!=0, IDLE->DONE on accept with op_b_i==0, CALC->FIX when counter reaches 0, FIX->DONE, DONE->IDLE unconditionally.
REQ-016 SHALL, on accept, latch operand magnitudes (negated if signed_i and MSB set), the sign flags and signed_i.
REQ-017 SHALL perform one restoring radix-2 step per CALC cycle on a 2*WIDTH+1 partial remainder; WIDTH steps by default.
REQ-018 SHALL, in FIX, negate quotient iff signs differ and negate remainder iff dividend negative (signed only).
REQ-019 SHALL assert done_o exactly in DONE; default latency accept->done_o = WIDTH+2 cycles.
REQ-020 SHALL, on divisor 0, give quo_o = all ones, rem_o = op_a_i unmodified, dbz_o=1, done_o 1 cycle after accept.
REQ-021 SHALL, for signed MIN / -1, give quo_o = MIN, rem_o = 0, dbz_o=0, with no special path.
REQ-022 SHALL ignore start_i while ready_o=0; operands changing during CALC SHALL not affect the result.
REQ-023 SHALL, on cancel_i=1 in CALC, FIX or DONE, enter IDLE next cycle with done_o=0 and quo_o/rem_o unchanged.
REQ-024 SHALL give cancel_i priority over start_i in the same IDLE cycle (no accept).

Reset
REQ-025 SHALL, on rst, enter IDLE with ready_o=1, done_o=0, quo_o=0, rem_o=0, dbz_o=0, counter 0.
REQ-026 SHALL, on rst mid-operation, discard the operation without any done_o pulse.

Configuration
REQ-027 SHALL support macro DIV_EARLY_OUT_EN: when defined, the dividend magnitude is pre-shifted by its leading-zero count lz on accept and CALC runs WIDTH-lz steps (0 steps if magnitude is 0, CALC skipped), latency = WIDTH-lz+2.
REQ-028 SHALL, without DIV_EARLY_OUT_EN, always run WIDTH steps; results SHALL be bit-identical in both builds.

Structure
REQ-029 SHALL place the state encoding and divide-by-zero result constants in shared package div_pkg.
REQ-030 SHALL use sub-module div_clz (parametrised leading-zero counter), instantiated only under DIV_EARLY_OUT_EN.

Verification
REQ-031 SHALL cover unsigned 100/7, WIDTH=32 -> quo 14, rem 2, done_o at cycle 34 after accept (macro off).
REQ-032 SHALL cover signed -7/2 -> quo 0xFFFFFFFD (-3), rem 0xFFFFFFFF (-1); 7/-2 -> quo -3, rem 1.
REQ-033 SHALL cover 0x12345678/0 -> quo 0xFFFFFFFF, rem 0x12345678, dbz_o=1, done_o 1 cycle after accept.
REQ-034 SHALL cover signed 0x80000000/0xFFFFFFFF -> quo 0x80000000, rem 0, dbz_o=0.
REQ-035 SHALL cover cancel_i at CALC cycle 10 -> IDLE next cycle, no done_o; new 9/3 then gives quo 3, rem 0.
REQ-036 SHALL cover, with DIV_EARLY_OUT_EN, unsigned 5/1 -> quo 5, rem 0, done_o 5 cycles after accept.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// constants used to build the divide-by-zero result.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // On divide by zero the quotient is filled with this bit and the flag is raised.
    localparam logic DBZ_QUO_BIT = 1'b1;
    localparam logic DBZ_FLAG    = 1'b1;

endpackage

// File: rtl/div_clz.sv
// Parametrised leading-zero counter; returns WIDTH for an all-zero input.
module div_clz #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]             i_val,
    output logic [$clog2(WIDTH+1)-1:0]   o_lz
);

    localparam int CNT_W = $clog2(WIDTH+1);

    // Ascending scan: the highest set bit is the last one to write o_lz.
    always_comb begin
        o_lz = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_val[i]) begin
                o_lz = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider, signed or unsigned, with cancel.
// Optional macro DIV_EARLY_OUT_EN skips the dividend's leading zeros.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             dbz_o,
    output div_state_t       dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH+1);
    localparam int PW    = 2*WIDTH + 1;

    // Handshake: an operation is accepted on a rising edge where start_i=1,
    // cancel_i=0 and ready_o=1; results are valid for the single cycle done_o=1
    // and quo_o/rem_o then hold until the next accept.

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_p;
    logic [WIDTH-1:0] r_b;
    logic             r_a_neg;
    logic             r_b_neg;
    logic             r_signed;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_a_init;
    logic [CNT_W-1:0] w_steps;
    logic [PW-1:0]    w_shift;
    logic [PW-1:0]    w_step;
    logic [WIDTH:0]   w_hi;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    assign w_a_neg = signed_i & op_a_i[WIDTH-1];
    assign w_b_neg = signed_i & op_b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? -op_a_i : op_a_i;
    assign w_b_mag = w_b_neg ? -op_b_i : op_b_i;

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] w_lz;

    div_clz #(.WIDTH(WIDTH)) u_clz (
        .i_val (w_a_mag),
        .o_lz  (w_lz)
    );

    // Pre-shifting drops leading zeros, so only the significant bits need a step.
    assign w_a_init = w_a_mag << w_lz;
    assign w_steps  = CNT_W'(WIDTH) - w_lz;
`else
    assign w_a_init = w_a_mag;
    assign w_steps  = CNT_W'(WIDTH);
`endif

    // One restoring step: shift left, subtract the divisor from the upper half if it fits.
    assign w_shift = r_p << 1;
    assign w_hi    = w_shift[PW-1:WIDTH];
    assign w_diff  = w_hi - {1'b0, r_b};
    assign w_step  = (w_hi >= {1'b0, r_b}) ? {w_diff, w_shift[WIDTH-1:1], 1'b1} : w_shift;

    assign w_q = r_p[WIDTH-1:0];
    assign w_r = r_p[2*WIDTH-1:WIDTH];

    assign ready_o     = (r_state == S_IDLE);
    assign dbg_state_o = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_p      <= '0;
            r_b      <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_signed <= 1'b0;
            done_o   <= 1'b0;
            quo_o    <= '0;
            rem_o    <= '0;
            dbz_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        r_b      <= w_b_mag;
                        r_a_neg  <= w_a_neg;
                        r_b_neg  <= w_b_neg;
                        r_signed <= signed_i;
                        r_p      <= {{(WIDTH+1){1'b0}}, w_a_init};
                        r_cnt    <= w_steps;
                        if (op_b_i == '0) begin
                            quo_o   <= {WIDTH{DBZ_QUO_BIT}};
                            rem_o   <= op_a_i;
                            dbz_o   <= DBZ_FLAG;
                            done_o  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else if (w_steps == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel_i) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_p   <= w_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        // MIN / -1 needs no special case: negating 2^(W-1) wraps back to MIN.
                        quo_o   <= (r_signed && (r_a_neg ^ r_b_neg)) ? -w_q : w_q;
                        rem_o   <= (r_signed && r_a_neg) ? -w_r : w_r;
                        dbz_o   <= 1'b0;
                        done_o  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
